// File: rtl/sum_share_ctrl.sv
// Two-requester round-robin front end for a single 4-bit adder: a winner's operands
// are summed one nibble per clock, LSB first, and returned with its requester id.
module sum_share_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_a,
   input  logic [WIDTH-1:0] a_x,
   input  logic [WIDTH-1:0] a_y,
   output logic             gnt_a,
   input  logic             req_b,
   input  logic [WIDTH-1:0] b_x,
   input  logic [WIDTH-1:0] b_y,
   output logic             gnt_b,
   output logic [WIDTH-1:0] res,
   output logic             res_carry,
   output logic             res_id,
   output logic             res_valid,
   output logic             busy
);

   localparam int NIB = WIDTH / 4;
   localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_reg;
   logic [WIDTH-1:0] x_reg;
   logic [WIDTH-1:0] y_reg;
   logic [WIDTH-1:0] acc_reg;
   logic             carry_reg;
   logic [KW-1:0]    k_reg;
   logic             last_id_reg;

   logic [3:0]       x_nib [NIB];
   logic [3:0]       y_nib [NIB];
   logic [4:0]       s5;
   logic [WIDTH-1:0] acc_next;
   logic             win_a;
   logic             win_b;
   logic             last_step;

   genvar gi;
   generate
      for (gi = 0; gi < NIB; gi++) begin : g_nib
         assign x_nib[gi] = x_reg[4*gi +: 4];
         assign y_nib[gi] = y_reg[4*gi +: 4];
         // Only the nibble selected by k is replaced; the rest of acc passes through.
         assign acc_next[4*gi +: 4] = (k_reg == KW'(gi)) ? s5[3:0] : acc_reg[4*gi +: 4];
      end
   endgenerate

   assign s5 = {1'b0, x_nib[k_reg]} + {1'b0, y_nib[k_reg]} + {4'b0000, carry_reg};

   // On a tie the requester that did not win last time goes first.
   assign win_a = req_a & (~req_b | last_id_reg);
   assign win_b = req_b & (~req_a | ~last_id_reg);

   assign last_step = (k_reg == KW'(NIB - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg   <= IDLE;
         x_reg       <= '0;
         y_reg       <= '0;
         acc_reg     <= '0;
         carry_reg   <= 1'b0;
         k_reg       <= '0;
         last_id_reg <= 1'b1;
         gnt_a       <= 1'b0;
         gnt_b       <= 1'b0;
         res         <= '0;
         res_carry   <= 1'b0;
         res_id      <= 1'b0;
         res_valid   <= 1'b0;
         busy        <= 1'b0;
      end else begin
         gnt_a     <= 1'b0;
         gnt_b     <= 1'b0;
         res_valid <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (win_a || win_b) begin
                  x_reg       <= win_b ? b_x : a_x;
                  y_reg       <= win_b ? b_y : a_y;
                  acc_reg     <= '0;
                  carry_reg   <= 1'b0;
                  k_reg       <= '0;
                  last_id_reg <= win_b;
                  gnt_a       <= win_a;
                  gnt_b       <= win_b;
                  busy        <= 1'b1;
                  state_reg   <= RUN;
               end
            end
            RUN: begin
               acc_reg   <= acc_next;
               carry_reg <= s5[4];
               k_reg     <= k_reg + KW'(1);
               if (last_step) begin
                  res       <= acc_next;
                  res_carry <= s5[4];
                  res_id    <= last_id_reg;
                  res_valid <= 1'b1;
                  state_reg <= DONE;
               end
            end
            DONE: begin
               busy      <= 1'b0;
               state_reg <= IDLE;
            end
            default: begin
               busy      <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/sum_share_ctrl.md
Name: sum_share_ctrl

Overview:
Round-robin arbiter and sequencer that shares one 4-bit nibble adder between two requesters, A and B.
The block adds WIDTH-bit operands serially, one nibble per clock, LSB nibble first, chaining the carry between nibbles.
It returns the result, the final carry and the requester ID with a one-cycle valid pulse.
It sits between the requester blocks and the 4-bit sum datapath, replacing per-requester wide adders.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4; NIB = WIDTH/4 nibble steps per operation.

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-high reset
req_a  input  1  requester A wants an addition; held until gnt_a seen
a_x  input  WIDTH  requester A operand X
a_y  input  WIDTH  requester A operand Y
gnt_a  output  1  one-cycle pulse: A's operands were captured
req_b  input  1  requester B request; same rules as req_a
b_x  input  WIDTH  requester B operand X
b_y  input  WIDTH  requester B operand Y
gnt_b  output  1  one-cycle pulse: B's operands were captured
res  output  WIDTH  sum of the last completed operation
res_carry  output  1  carry out of the MSB nibble of the last operation
res_id  output  1  owner of res: 0 = A, 1 = B
res_valid  output  1  one-cycle pulse: res, res_carry and res_id are new
busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset, asynchronous, effective immediately:
  - state = IDLE.
  - gnt_a, gnt_b, res, res_carry, res_id, res_valid and busy all = 0.
  - Internal carry, nibble counter and operand registers cleared.
  - last_id = 1, so A wins the first tie.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE, arbitration at the clock edge:
  - Only one request high: that requester wins.
  - Both high: the requester not equal to last_id wins.
  - On a win: capture the winner's x/y, set last_id = winner, k = 0, carry = 0, go to RUN.
  - The matching gnt_* is high for exactly the cycle following that edge.
  - No request: stay in IDLE.
- Requester obligations:
  - Hold req and operands stable until gnt is seen.
  - Deassert req during the gnt cycle.
  - req still high after the gnt cycle is treated as a new request.
- RUN, each edge processes nibble k:
  - s5 = x[4k+3:4k] + y[4k+3:4k] + carry, computed 5 bits wide.
  - acc[4k+3:4k] <= s5[3:0]; carry <= s5[4]; k <= k+1.
  - The edge that processes k = NIB-1 moves to DONE and loads res = acc (final nibble included), res_carry = s5[4], res_id = last_id.
- DONE:
  - res_valid = 1 for exactly this one cycle; the next edge returns to IDLE.
  - res, res_carry and res_id hold until the next DONE load.
  - They do not change during RUN.
- Latency: capture edge E0; gnt in cycle E0+1; res_valid in cycle E0+NIB+1.
  - For WIDTH = 16: gnt in cycle 1, res_valid in cycle 5.
  - Earliest next capture is at the edge ending the first IDLE cycle after DONE.
  - Throughput is one operation per NIB+2 cycles.
- Requests arriving while busy get no grant and stay pending; they are arbitrated at the next IDLE edge.
- Reset mid-operation aborts the operation. No res_valid is produced for it, and no grant is issued until a fresh IDLE arbitration.
- The sum wraps modulo 2^WIDTH; the overflow bit is reported only in res_carry.
- gnt_a and gnt_b are never high in the same cycle.
- res_valid and any gnt are never high in the same cycle.

Test Plan:
1. WIDTH=16; req_a with a_x=0x1234, a_y=0x0F0F -> gnt_a in cycle 1; res_valid in cycle 5 with res=0x2143, res_carry=0, res_id=0; busy high in cycles 1-5.
2. req_b with 0xFFFF + 0x0001 -> carry ripples through all 4 nibbles: res=0x0000, res_carry=1, res_id=1.
3. req_a and req_b both held continuously -> grant order A, B, A, B; each res_id matches; with b = 0x8000 + 0x8000, B's result is res=0x0000, res_carry=1.
4. req_b raised during A's RUN -> gnt_b stays low through A's DONE; B is granted at the first IDLE edge after A's DONE; A's result is unaffected.
5. reset pulsed in RUN cycle 2 -> all outputs 0 immediately, no res_valid follows; after release, req_a and req_b together -> A granted first (last_id reset to 1).
6. WIDTH=8; req_a with 0xAB + 0x55 -> gnt_a in cycle 1; res_valid in cycle 3 with res=0x00, res_carry=1.
